// File: rtl/fft_out_serializer_pkg.sv
// fft_out_serializer_pkg
// Shared headers for the FFT datapath blocks.
//   FFT_N_DEFAULT     : default transform size used by the FFT blocks.
//   complex_product_t : one complex sample, signed real/imag parts of CP_W bits.
//   bitrev()          : reverses the low 'width' bits of a value (0 < width <= 32).
package fft_out_serializer_pkg;

  localparam int FFT_N_DEFAULT = 8;
  localparam int CP_W          = 16;

  typedef struct packed {
    logic signed [CP_W-1:0] r;
    logic signed [CP_W-1:0] i;
  } complex_product_t;

  // Bits at or above 'width' come back as zero, so callers can truncate
  // the result to their own index width.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] result;
    result = '0;
    for (int k = 0; k < 32; k++) begin
      if (k < width) result[k] = value[width-1-k];
    end
    return result;
  endfunction

endpackage

// File: rtl/fft_out_serializer.sv
// fft_out_serializer
// Captures a parallel FFT result frame into one of two ping-pong banks and
// streams it out one complex sample per cycle over valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   frame present on fft_in (driven by the FFT out_valid)
//   fft_in     parallel FFT result, N samples
//   in_ready   at least one bank is empty (combinational)
//   out_data   current output sample (zero while out_valid is low)
//   out_index  frequency bin of out_data
//   out_last   high with bin N-1
//   out_valid  out_data is valid
//   out_ready  downstream accepts the sample
//   overflow   one-cycle pulse, the cycle after a frame was dropped
//
// Build option:
//   FFT_SERIALIZER_BITREV_EN  defined: read each bank in bit-reversed address
//                             order, turning the radix-2 core's decimated output
//                             into natural bin order. Undefined: capture order.
module fft_out_serializer
  import fft_out_serializer_pkg::*;
#(
  parameter  int N  = FFT_N_DEFAULT,
  localparam int IW = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  complex_product_t [N-1:0] fft_in,
  output logic                     in_ready,
  output complex_product_t         out_data,
  output logic [IW-1:0]            out_index,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow
);

  complex_product_t [N-1:0] bank [2];
  logic [1:0]               full;
  logic                     wp;
  logic                     rp;
  logic [IW-1:0]            rc;
  logic [IW-1:0]            rd_idx;
  logic                     capture;
  logic                     transfer;
  logic                     last_read;

  assign in_ready  = !(full[0] && full[1]);
  assign capture   = in_valid && in_ready;
  assign out_valid = full[rp];
  assign transfer  = out_valid && out_ready;
  assign last_read = (rc == IW'(N-1));

  // Whenever a bank is full, wp already points at the other one, so a
  // capture and the final read of the draining bank never touch the same
  // full flag and both can happen on one edge.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      full     <= '0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      rc       <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= in_valid && !in_ready;
      if (capture) begin
        full[wp] <= 1'b1;
        wp       <= ~wp;
      end
      if (transfer) begin
        if (last_read) begin
          rc       <= '0;
          full[rp] <= 1'b0;
          rp       <= ~rp;
        end else begin
          rc <= rc + 1'b1;
        end
      end
    end
  end

  // NOTE: the bank array has no reset; its contents are only observable
  // through a full flag, and those are reset, so clearing the storage would
  // just cost a reset net on every data flop.
  always_ff @(posedge clk) begin
    if (capture) bank[wp] <= fft_in;
  end

  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    rd_idx = rc;
`ifdef FFT_SERIALIZER_BITREV_EN
    rd_idx = IW'(bitrev(32'(rc), IW));
`endif
    out_data = '0;
    if (out_valid) out_data = bank[rp][rd_idx];
  end

  // rc only advances on a transfer, so index/last/data hold during a stall.
  assign out_index = rc;
  assign out_last  = out_valid && last_read;

endmodule

// File: tb/tb_fft_out_serializer.sv
module tb_fft_out_serializer;
  import fft_out_serializer_pkg::*;

  localparam int N  = 8;
  localparam int IW = 3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  complex_product_t [N-1:0] fft_in;
  logic                     in_ready;
  complex_product_t         out_data;
  logic [IW-1:0]            out_index;
  logic                     out_last;
  logic                     out_valid;
  logic                     out_ready;
  logic                     overflow;

  int checks = 0;
  int passed = 0;

`ifdef FFT_SERIALIZER_BITREV_EN
  int order [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
  int order [N] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

  fft_out_serializer #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .fft_in    (fft_in),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // a further unit later, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load_frame(input int base);
    for (int j = 0; j < N; j++) begin
      fft_in[j].r = 16'(base + 100 * j);
      fft_in[j].i = 16'(-j);
    end
  endtask

  function automatic complex_product_t expect_sample(input int base, input int k);
    complex_product_t s;
    s.r = 16'(base + 100 * order[k]);
    s.i = 16'(-order[k]);
    return s;
  endfunction

  task automatic check_sample(input string tag, input int base, input int k);
    check({tag, ".valid"}, 32'(out_valid), 32'(1));
    check({tag, ".index"}, 32'(out_index), 32'(k));
    check({tag, ".data"}, 32'(out_data), 32'(expect_sample(base, k)));
    check({tag, ".last"}, 32'(out_last), 32'(k == N - 1));
  endtask

  initial begin
    int k;
    int budget;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    load_frame(0);
    tick();
    tick();
    reset = 1'b0;
    settle();

    // Reset state
    check("rst.in_ready", 32'(in_ready), 32'(1));
    check("rst.out_valid", 32'(out_valid), 32'(0));
    check("rst.out_data", 32'(out_data), 32'(0));
    check("rst.out_index", 32'(out_index), 32'(0));
    check("rst.out_last", 32'(out_last), 32'(0));
    check("rst.overflow", 32'(overflow), 32'(0));

    // Single frame, full-rate drain in the configured order
    load_frame(0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    settle();
    for (int s = 0; s < N; s++) begin
      check_sample("single", 0, s);
      tick();
      settle();
    end
    check("single.done_valid", 32'(out_valid), 32'(0));

    // Back-to-back frames: B captured on the edge that reads A's last bin
    load_frame(1000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    settle();
    for (int s = 0; s < 2 * N; s++) begin
      check_sample(s < N ? "b2b.A" : "b2b.B", s < N ? 1000 : 2000, s % N);
      if (s == N - 1) begin
        load_frame(2000);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      settle();
      check("b2b.in_ready", 32'(in_ready), 32'(1));
      check("b2b.overflow", 32'(overflow), 32'(0));
      tick();
      in_valid = 1'b0;
      settle();
    end
    check("b2b.done_valid", 32'(out_valid), 32'(0));

    // Backpressure: two frames captured, the third dropped
    out_ready = 1'b0;
    load_frame(3000);
    in_valid = 1'b1;
    tick();
    settle();
    check("bp.ready_after1", 32'(in_ready), 32'(1));
    load_frame(4000);
    tick();
    settle();
    check("bp.ready_after2", 32'(in_ready), 32'(0));
    check("bp.ovf_before", 32'(overflow), 32'(0));
    load_frame(5000);
    tick();
    in_valid = 1'b0;
    settle();
    check("bp.ovf_pulse", 32'(overflow), 32'(1));
    check("bp.hold_index", 32'(out_index), 32'(0));
    tick();
    settle();
    check("bp.ovf_clear", 32'(overflow), 32'(0));
    check_sample("bp.held", 3000, 0);
    out_ready = 1'b1;
    settle();
    for (int s = 0; s < 2 * N; s++) begin
      check_sample(s < N ? "bp.C" : "bp.D", s < N ? 3000 : 4000, s % N);
      tick();
      settle();
      if (s == N - 1) check("bp.ready_freed", 32'(in_ready), 32'(1));
    end
    check("bp.done_valid", 32'(out_valid), 32'(0));

    // Stall stability: out_ready toggles every cycle
    load_frame(6000);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    k = 0;
    budget = 0;
    while (k < N && budget < 40) begin
      out_ready = budget[0];
      settle();
      check_sample("stall", 6000, k);
      tick();
      if (out_ready) k++;
      budget++;
    end
    check("stall.bins_drained", 32'(k), 32'(N));
    out_ready = 1'b0;
    settle();
    check("stall.done_valid", 32'(out_valid), 32'(0));

    // Reset after three samples of a frame
    load_frame(7000);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    settle();
    for (int s = 0; s < 3; s++) begin
      check_sample("rmid", 7000, s);
      tick();
      settle();
    end
    check("rmid.index3", 32'(out_index), 32'(3));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("rmid.out_valid", 32'(out_valid), 32'(0));
    check("rmid.in_ready", 32'(in_ready), 32'(1));
    check("rmid.out_index", 32'(out_index), 32'(0));
    check("rmid.out_data", 32'(out_data), 32'(0));
    load_frame(8000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    settle();
    for (int s = 0; s < N; s++) begin
      check_sample("rmid.new", 8000, s);
      tick();
      settle();
    end
    check("rmid.done_valid", 32'(out_valid), 32'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
